// File: rtl/vx_sp_ram_ctrl.sv
// Single-port RAM controller: power-up/on-demand initialization sweep,
// read/write request port and a 2-entry in-order read response FIFO.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | sweep INIT_VALUE into entries 0..SIZE-1, one per cycle
// ST_RUN   | accept read/write requests while response credit remains
// ST_DRAIN | re-init requested; hold off requests until responses are out
module vx_sp_ram_ctrl #(
    parameter int                DATAW      = 32,
    parameter int                SIZE       = 16,
    parameter int                ADDRW      = $clog2(SIZE),
    parameter int                OUT_REG    = 0,
    parameter logic [DATAW-1:0]  INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_req,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [DATAW-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_data,
    output logic             init_busy,
    output logic [ADDRW-1:0] ram_addr,
    output logic             ram_wren,
    output logic [DATAW-1:0] ram_wdata,
    input  logic [DATAW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

    state_t           state_q, state_d;
    logic [ADDRW-1:0] sweep_q, sweep_d;

    // read pipeline and response FIFO
    logic             rd_pend_q;
    logic [1:0]       cnt_q;
    logic [DATAW-1:0] fifo_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;

    logic             rd_fire;
    logic             cap_en;
    logic             pop;
    logic [1:0]       credit_used;

    // A read occupies one credit from acceptance until it is popped, so the
    // FIFO can never be asked to hold a third entry.
    assign credit_used = {1'b0, rd_pend_q} + cnt_q;
    assign rd_fire     = req_valid && req_ready && !req_rw;
    assign cap_en      = (OUT_REG != 0) ? rd_pend_q : rd_fire;
    assign rsp_valid   = (cnt_q != 2'd0);
    assign pop         = rsp_valid && rsp_ready;
    assign rsp_data    = rsp_valid ? fifo_q[rd_ptr_q] : '0;

    // state and sweep address register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // next-state, handshake and RAM-side drive
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        req_ready = 1'b0;
        init_busy = 1'b0;
        ram_addr  = '0;
        ram_wren  = 1'b0;
        ram_wdata = '0;
        case (state_q)
            ST_INIT: begin
                init_busy = 1'b1;
                // No RAM writes while reset is held; the sweep starts on the
                // first cycle with reset released.
                if (reset) begin
                    ram_addr  = sweep_q;
                    ram_wren  = 1'b1;
                    ram_wdata = INIT_VALUE;
                    if (sweep_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                        sweep_d = '0;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Requests are refused in the cycle init_req is seen so that
                // nothing new is accepted on the way into DRAIN.
                if (init_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    req_ready = (credit_used < 2'd2);
                    if (req_valid && req_ready) begin
                        ram_addr = req_addr;
                        ram_wren = req_rw;
                        if (req_rw) begin
                            ram_wdata = req_data;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!rd_pend_q && (cnt_q == 2'd0)) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // read data capture and response FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_pend_q <= 1'b0;
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            rd_pend_q <= (OUT_REG != 0) && rd_fire;
            if (cap_en) begin
                fifo_q[wr_ptr_q] <= ram_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({cap_en, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: doc/vx_sp_ram_ctrl.md
VX_SP_RAM_CTRL -- requirements
Module: VX_sp_ram_ctrl

Interface
REQ-001 SHALL have parameter DATAW, default 32: data width in bits.
REQ-002 SHALL have parameter SIZE, default 16: number of RAM entries, at least 2.
REQ-003 SHALL have parameter ADDRW, default $clog2(SIZE): address width.
REQ-004 SHALL have parameter OUT_REG, default 0: read latency of the attached RAM; 0 means combinational rdata, 1 means registered rdata.
REQ-005 SHALL have parameter INIT_VALUE [DATAW-1:0], default 0: value written to every entry during initialization.
REQ-006 SHALL have one clock and one reset: clk  in  1  single clock; reset is synchronous and active-low.
REQ-007 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-008 SHALL have port init_req  in  1  level request to re-initialize the RAM.
REQ-009 SHALL have ports req_valid/req_ready  in/out  1  request handshake.
REQ-010 SHALL have ports req_rw  in  1 (1 = write); req_addr  in  ADDRW; req_data  in  DATAW.
REQ-011 SHALL have ports rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  DATAW; these carry read responses.
REQ-012 SHALL have port init_busy  out  1  high while the initialization sweep runs.
REQ-013 SHALL have RAM-side ports ram_addr  out  ADDRW; ram_wren  out  1; ram_wdata  out  DATAW; ram_rdata  in  DATAW. These drive a single-port RAM with matching OUT_REG.

Function
REQ-014 SHALL implement the states INIT, RUN and DRAIN.
REQ-015 In INIT, SHALL write INIT_VALUE to addresses 0..SIZE-1, one per cycle in ascending order, with ram_wren=1 and init_busy=1; req_ready SHALL be 0.
REQ-016 After the write to SIZE-1, SHALL go to RUN on the next cycle, and init_busy SHALL fall on that cycle.
REQ-017 A request SHALL be accepted on a cycle with req_valid && req_ready; at most one request is accepted per cycle.
REQ-018 An accepted write SHALL drive ram_addr=req_addr, ram_wren=1 and ram_wdata=req_data in the same cycle, and SHALL produce no response.
REQ-019 An accepted read SHALL drive ram_addr=req_addr with ram_wren=0.
REQ-020 For an accepted read, ram_rdata SHALL be captured in the same cycle when OUT_REG=0, or one cycle later when OUT_REG=1.
REQ-021 Captured read data SHALL enter a 2-entry response FIFO; rsp_valid SHALL rise the cycle after capture, giving a read-to-rsp_valid latency of 1+OUT_REG cycles when the FIFO is empty.
REQ-022 Responses SHALL be returned in request order; rsp_data SHALL stay stable while rsp_valid && !rsp_ready.
REQ-023 In RUN, req_ready SHALL be 1 only when (reads in flight) + (FIFO occupancy) < 2, so the FIFO never overflows and no response is dropped.
REQ-024 A FIFO pop and a capture in the same cycle SHALL leave the occupancy unchanged.
REQ-025 Writes SHALL follow the same req_ready rule, which keeps the rule uniform.
REQ-026 A read of an address written in the previous cycle SHALL return the new data.
REQ-027 When init_req=1 in RUN, the block SHALL go to DRAIN with req_ready=0.
REQ-028 DRAIN SHALL go to INIT once no reads are in flight and the FIFO is empty; responses SHALL continue to be delivered during DRAIN.
REQ-029 init_req SHALL be ignored in INIT and DRAIN, and a sweep SHALL never be aborted by init_req.
REQ-030 When idle, ram_addr, ram_wren and ram_wdata SHALL be 0.

Reset
REQ-031 While reset=0 at a clk edge: state SHALL become INIT with sweep address 0, the FIFO SHALL empty, in-flight reads SHALL be discarded, rsp_valid=0, rsp_data=0, req_ready=0, init_busy=1, ram_wren=0.
REQ-032 A reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0 on the first cycle after reset=1.

Verification (DATAW=32, SIZE=16)
REQ-033 Release reset, then hold init_req=0 -> exactly 16 cycles of ram_wren=1 with addresses 0..15, data=INIT_VALUE; init_busy falls on cycle 17, and then req_ready=1.
REQ-034 With OUT_REG=0: write 0xDEADBEEF to address 5, then read address 5 on the next cycle -> rsp_valid one cycle after the read with rsp_data=0xDEADBEEF.
REQ-035 With OUT_REG=1 and rsp_ready=0: back-to-back reads of addresses 1 and 2 -> req_ready=0 after the second accept, with no loss. Then set rsp_ready=1 -> responses arrive in order 1, 2, and req_ready returns to 1.
REQ-036 Pop the FIFO and capture a read in the same cycle -> occupancy stays 1 and data order is preserved.
REQ-037 Assert init_req with 2 responses pending -> DRAIN until both are popped, then a 16-cycle sweep; a later read of address 5 returns INIT_VALUE.
REQ-038 Pulse reset=0 at sweep address 9 -> sweep restarts at address 0 and runs all 16 entries.
